regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-read-port integer register file; successor of the single-core-port register file.
- Sits between ID (reads), EX/WB (core write) and the debug/JTAG controller.
- Adds a configurable number of read ports and a self-clearing init sequencer.
- Debug access goes through a req/ack handshake with defined arbitration against core writes.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register address width; DEPTH = 2**ADDR_W registers
NUM_RD, 2, number of combinational read ports (1..4)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-low reset
we_i  in  1  core write enable (from EX/WB)
waddr_i  in  ADDR_W  core write address
wdata_i  in  DATA_W  core write data
raddr_i  in  NUM_RD*ADDR_W  packed read addresses; port k at bits [k*ADDR_W +: ADDR_W]
rdata_o  out  NUM_RD*DATA_W  packed read data; port k at bits [k*DATA_W +: DATA_W]
dbg_req_i  in  1  debug access request; held high until dbg_ack_o
dbg_we_i  in  1  debug access is a write (1) or a read (0)
dbg_addr_i  in  ADDR_W  debug register address
dbg_wdata_i  in  DATA_W  debug write data
dbg_ack_o  out  1  one-cycle access-complete pulse
dbg_rdata_o  out  DATA_W  debug read result, valid while dbg_ack_o=1
init_done_o  out  1  high once all registers are cleared

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-low (rst=0 sampled at posedge clk).
- Register 0:
  - Hardwired zero; never written.
  - Any read of address 0 returns 0, including the debug port.
- Reset values:
  - init_done_o=0, dbg_ack_o=0, dbg_rdata_o=0.
  - FSM goes to INIT with init pointer = 1.
  - Register array contents are not reset directly; they are cleared by INIT.
- FSM states: INIT and RUN.
  - INIT: each cycle, clears regs[ptr] and increments ptr. When ptr = DEPTH-1 has been cleared, go to RUN.
  - INIT therefore lasts DEPTH-1 cycles after rst is released; init_done_o is high from the first RUN cycle.
  - RUN: normal operation; RUN is left only by reset.
- Behaviour during INIT:
  - Core writes are ignored; the pipeline is held off by init_done_o.
  - All rdata_o ports return 0.
  - dbg_req_i is not acknowledged.
- Reset mid-operation: rst=0 in any state aborts INIT or any pending debug access. dbg_ack_o=0 next cycle; INIT restarts from ptr=1.
- Core write (RUN): if we_i=1 and waddr_i≠0, regs[waddr_i] <= wdata_i at the posedge.
- Read ports: purely combinational; each port is independent.
  - Address 0 gives 0.
  - Otherwise the stored value, subject to the bypass rule in Optional Feature.
  - Multiple ports reading the same address return identical data.
- Debug handshake (RUN), acceptance condition:
  - An access is accepted at a posedge when dbg_req_i=1 and dbg_ack_o=0.
  - A write is additionally only accepted when NOT (we_i=1 and waddr_i≠0); the core write has priority and the debug write stalls.
  - A read is never stalled by a core write.
- Debug access on acceptance:
  - Write: regs[dbg_addr_i] <= dbg_wdata_i, unless the address is 0 (ignored, still acked); dbg_rdata_o <= dbg_wdata_i.
  - Read: dbg_rdata_o <= stored value of regs[dbg_addr_i] (pre-edge contents; 0 for address 0).
  - dbg_ack_o = 1 for exactly the following cycle, then 0.
  - The requester drops or changes dbg_req_i in the ack cycle; no acceptance occurs while dbg_ack_o=1, so back-to-back accesses take at least 2 cycles each.
- Simultaneous events:
  - A core write and a debug read to the same address in the same cycle: the debug read returns the old value.
  - dbg_rdata_o holds its value until the next acceptance.

Optional Feature:
- Macro: REGFILE_MP_BYPASS_EN.
- Defined: write-to-read forwarding in RUN. A read port whose address equals waddr_i, with we_i=1 and address≠0, returns wdata_i in the same cycle. This has priority over the stored value.
- Undefined: reads return stored contents only; a core write becomes visible in the cycle after the write edge. Saves the NUM_RD comparators.

Test Plan:
- Reset/init: rst low 2 cycles, then high, DEPTH=32 → init_done_o rises exactly 31 cycles later. All read ports return 0x0 for addresses 1..31. dbg_req_i held during INIT gets no ack.
- Core write/read: write 0xDEADBEEF to x5 → next cycle, ports 0 and 1 both reading x5 return 0xDEADBEEF. A write of 0x1234 to x0 → x0 reads 0.
- Bypass: with the macro defined, write x7=0xA5A5A5A5 and read x7 in the same cycle → 0xA5A5A5A5. With the macro undefined, the read returns the previous value 0x0.
- Debug arbitration: debug write x3=0x55 and core write x9=0x77 in the same cycle → debug stalls one cycle. Ack follows the first non-conflicting edge; then x3=0x55 and x9=0x77.
- Debug read: core writes x4=0x10, then debug read x4 → dbg_ack_o pulse of 1 cycle with dbg_rdata_o=0x10. Debug read of x0 → 0x0, acked.
- Reset mid-op: assert rst during the 10th INIT cycle and while a debug request is pending → ack never issues. INIT restarts; init_done_o follows 31 cycles after release.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-read-port integer register file with self-clearing init sequencer and debug req/ack port.
// Optional write-to-read forwarding on the read ports: define REGFILE_MP_BYPASS_EN.
module regfile_mp #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned NUM_RD = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       we_i,
   input  logic [ADDR_W-1:0]          waddr_i,
   input  logic [DATA_W-1:0]          wdata_i,
   input  logic [NUM_RD*ADDR_W-1:0]   raddr_i,
   output logic [NUM_RD*DATA_W-1:0]   rdata_o,
   input  logic                       dbg_req_i,
   input  logic                       dbg_we_i,
   input  logic [ADDR_W-1:0]          dbg_addr_i,
   input  logic [DATA_W-1:0]          dbg_wdata_i,
   output logic                       dbg_ack_o,
   output logic [DATA_W-1:0]          dbg_rdata_o,
   output logic                       init_done_o
);

   localparam int unsigned DEPTH = 2**ADDR_W;

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   state_t              r_state, w_state_nxt;
   logic [ADDR_W-1:0]   r_ptr, w_ptr_nxt;
   logic                w_clear;
   logic [DATA_W-1:0]   r_regs [DEPTH];
   logic                r_init_done;
   logic                r_dbg_ack;
   logic [DATA_W-1:0]   r_dbg_rdata;
   logic                w_run;
   logic                w_core_we;
   logic                w_dbg_accept;
   logic                w_dbg_we;
   logic [DATA_W-1:0]   w_dbg_rd;
   logic [ADDR_W-1:0]   w_raddr [NUM_RD];

   // State register
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= ST_INIT;
         r_ptr   <= ADDR_W'(1);
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
      end
   end

   // Next state: INIT walks the pointer over registers 1..DEPTH-1, then RUN until reset
   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_clear     = 1'b0;
      case (r_state)
         ST_INIT: begin
            w_clear   = 1'b1;
            w_ptr_nxt = r_ptr + ADDR_W'(1);
            if (r_ptr == ADDR_W'(DEPTH - 1)) begin
               w_state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            w_state_nxt = ST_RUN;
         end
         default: begin
            w_state_nxt = ST_INIT;
         end
      endcase
   end

   assign w_run     = (r_state == ST_RUN);
   assign w_core_we = w_run && we_i && (waddr_i != '0);

   // Debug writes yield to a same-cycle core write; debug reads never stall
   assign w_dbg_accept = w_run && dbg_req_i && !r_dbg_ack && (!dbg_we_i || !w_core_we);
   assign w_dbg_we     = w_dbg_accept && dbg_we_i && (dbg_addr_i != '0);
   assign w_dbg_rd     = (dbg_addr_i == '0) ? '0 : r_regs[dbg_addr_i];

   // Storage: no reset; contents are cleared by the INIT walk
   always_ff @(posedge clk) begin
      if (rst) begin
         if (w_clear) begin
            r_regs[r_ptr] <= '0;
         end else if (w_core_we) begin
            r_regs[waddr_i] <= wdata_i;
         end else if (w_dbg_we) begin
            r_regs[dbg_addr_i] <= dbg_wdata_i;
         end
      end
   end

   // Registered status and debug response
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_init_done <= 1'b0;
         r_dbg_ack   <= 1'b0;
         r_dbg_rdata <= '0;
      end else begin
         r_init_done <= (w_state_nxt == ST_RUN);
         r_dbg_ack   <= w_dbg_accept;
         if (w_dbg_accept) begin
            r_dbg_rdata <= dbg_we_i ? dbg_wdata_i : w_dbg_rd;
         end
      end
   end

   for (genvar k = 0; k < NUM_RD; k++) begin : g_raddr
      assign w_raddr[k] = raddr_i[k*ADDR_W +: ADDR_W];
   end

   // Combinational read ports; all zero until init completes
   always_comb begin
      rdata_o = '0;
      for (int k = 0; k < NUM_RD; k++) begin
         if (!w_run || (w_raddr[k] == '0)) begin
            rdata_o[k*DATA_W +: DATA_W] = '0;
`ifdef REGFILE_MP_BYPASS_EN
         end else if (w_core_we && (w_raddr[k] == waddr_i)) begin
            rdata_o[k*DATA_W +: DATA_W] = wdata_i;
`endif
         end else begin
            rdata_o[k*DATA_W +: DATA_W] = r_regs[w_raddr[k]];
         end
      end
   end

   assign dbg_ack_o   = r_dbg_ack;
   assign dbg_rdata_o = r_dbg_rdata;
   assign init_done_o = r_init_done;

endmodule

// File: tb/tb_regfile_mp.sv
// Testbench for regfile_mp: behavioural model checked every negedge plus directed literal checks.
module tb_regfile_mp;

   logic        clk = 1'b0;
   logic        rst;
   logic        we_i;
   logic [4:0]  waddr_i;
   logic [31:0] wdata_i;
   logic [9:0]  raddr_i;
   logic [63:0] rdata_o;
   logic        dbg_req_i;
   logic        dbg_we_i;
   logic [4:0]  dbg_addr_i;
   logic [31:0] dbg_wdata_i;
   logic        dbg_ack_o;
   logic [31:0] dbg_rdata_o;
   logic        init_done_o;

   int n_checks = 0;
   int n_fail   = 0;

   regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) dut (
      .clk(clk), .rst(rst),
      .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
      .raddr_i(raddr_i), .rdata_o(rdata_o),
      .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i), .dbg_addr_i(dbg_addr_i),
      .dbg_wdata_i(dbg_wdata_i), .dbg_ack_o(dbg_ack_o), .dbg_rdata_o(dbg_rdata_o),
      .init_done_o(init_done_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: register contents, init progress and debug response
   logic [31:0] m_regs [32];
   bit          m_valid = 0;
   bit          m_done;
   int          m_cnt;
   bit          m_ack;
   logic [31:0] m_rdata;

   always @(posedge clk) begin
      bit core, acc;
      if (!rst) begin
         m_valid = 1;
         m_cnt   = 0;
         m_done  = 0;
         m_ack   = 0;
         m_rdata = 32'h0;
      end else if (m_valid && !m_done) begin
         m_cnt++;
         m_ack = 0;
         if (m_cnt == 31) begin
            m_done = 1;
            for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
         end
      end else if (m_valid) begin
         core = we_i && (waddr_i != 0);
         acc  = dbg_req_i && !m_ack && (!dbg_we_i || !core);
         if (acc) m_rdata = dbg_we_i ? dbg_wdata_i : ((dbg_addr_i == 0) ? 32'h0 : m_regs[dbg_addr_i]);
         if (core) m_regs[waddr_i] = wdata_i;
         if (acc && dbg_we_i && dbg_addr_i != 0) m_regs[dbg_addr_i] = dbg_wdata_i;
         m_ack = acc;
      end
   end

   function automatic logic [31:0] exp_rd(input logic [4:0] a);
      if (!m_done || a == 0) return 32'h0;
`ifdef REGFILE_MP_BYPASS_EN
      if (we_i && waddr_i != 0 && waddr_i == a) return wdata_i;
`endif
      return m_regs[a];
   endfunction

   always @(negedge clk) begin
      if (m_valid) begin
         check("init_done", 32'(init_done_o), 32'(m_done));
         check("dbg_ack", 32'(dbg_ack_o), 32'(m_ack));
         check("dbg_rdata", dbg_rdata_o, m_rdata);
         check("rdata_p0", rdata_o[31:0], exp_rd(raddr_i[4:0]));
         check("rdata_p1", rdata_o[63:32], exp_rd(raddr_i[9:5]));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Counts edges until init_done_o rises, bounded
   task automatic wait_init(input string name);
      int n = 0;
      for (int i = 1; i <= 40; i++) begin
         step();
         if (dbg_ack_o) check({name, "_no_ack"}, 32'(dbg_ack_o), 32'h0);
         if (init_done_o) begin
            n = i;
            break;
         end
      end
      check({name, "_len"}, 32'(n), 32'd31);
   endtask

   initial begin
      logic [4:0] av;
      rst = 1'b0; we_i = 1'b0; waddr_i = '0; wdata_i = '0; raddr_i = '0;
      dbg_req_i = 1'b0; dbg_we_i = 1'b0; dbg_addr_i = '0; dbg_wdata_i = '0;
      step(); step();
      check("rst_init_done", 32'(init_done_o), 32'h0);
      check("rst_dbg_ack", 32'(dbg_ack_o), 32'h0);
      check("rst_dbg_rdata", dbg_rdata_o, 32'h0);

      // Release reset with a debug read pending through INIT
      rst = 1'b1;
      dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 5'd3;
      wait_init("init");
      dbg_req_i = 1'b0;

      for (int a = 1; a < 32; a++) begin
         step();
         av = 5'(a);
         raddr_i = {av, av};
         #1;
         check("cleared_p0", rdata_o[31:0], 32'h0);
         check("cleared_p1", rdata_o[63:32], 32'h0);
      end

      // Core write then dual-port read
      step();
      we_i = 1'b1; waddr_i = 5'd5; wdata_i = 32'hDEADBEEF; raddr_i = {5'd5, 5'd5};
      step();
      we_i = 1'b0;
      #1;
      check("x5_p0", rdata_o[31:0], 32'hDEADBEEF);
      check("x5_p1", rdata_o[63:32], 32'hDEADBEEF);

      we_i = 1'b1; waddr_i = 5'd0; wdata_i = 32'h1234; raddr_i = {5'd0, 5'd0};
      step();
      we_i = 1'b0;
      #1;
      check("x0_read", rdata_o[31:0], 32'h0);

      // Same-cycle write/read of x7
      we_i = 1'b1; waddr_i = 5'd7; wdata_i = 32'hA5A5A5A5; raddr_i = {5'd5, 5'd7};
      #1;
`ifdef REGFILE_MP_BYPASS_EN
      check("bypass_x7", rdata_o[31:0], 32'hA5A5A5A5);
`else
      check("nobypass_x7", rdata_o[31:0], 32'h0);
`endif
      step();
      we_i = 1'b0;
      #1;
      check("x7_after", rdata_o[31:0], 32'hA5A5A5A5);

      // Debug write stalls behind a core write
      dbg_req_i = 1'b1; dbg_we_i = 1'b1; dbg_addr_i = 5'd3; dbg_wdata_i = 32'h55;
      we_i = 1'b1; waddr_i = 5'd9; wdata_i = 32'h77;
      step();
      we_i = 1'b0;
      check("arb_stall_ack", 32'(dbg_ack_o), 32'h0);
      step();
      check("arb_ack", 32'(dbg_ack_o), 32'h1);
      check("arb_rdata", dbg_rdata_o, 32'h55);
      dbg_req_i = 1'b0;
      step();
      check("arb_ack_drop", 32'(dbg_ack_o), 32'h0);
      raddr_i = {5'd9, 5'd3};
      #1;
      check("arb_x3", rdata_o[31:0], 32'h55);
      check("arb_x9", rdata_o[63:32], 32'h77);

      // Debug read of a core-written register
      we_i = 1'b1; waddr_i = 5'd4; wdata_i = 32'h10;
      step();
      we_i = 1'b0;
      dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 5'd4;
      step();
      check("dbgrd_ack", 32'(dbg_ack_o), 32'h1);
      check("dbgrd_x4", dbg_rdata_o, 32'h10);
      dbg_req_i = 1'b0;
      step();
      check("dbgrd_ack_pulse", 32'(dbg_ack_o), 32'h0);
      check("dbgrd_hold", dbg_rdata_o, 32'h10);

      dbg_req_i = 1'b1; dbg_addr_i = 5'd0;
      step();
      check("dbgrd_x0_ack", 32'(dbg_ack_o), 32'h1);
      check("dbgrd_x0", dbg_rdata_o, 32'h0);
      dbg_req_i = 1'b0;
      step();

      // Debug read collides with core write: old value returned
      we_i = 1'b1; waddr_i = 5'd4; wdata_i = 32'h99;
      dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 5'd4;
      step();
      we_i = 1'b0;
      check("collide_old", dbg_rdata_o, 32'h10);
      // Held request: next acceptance only after the ack cycle
      step();
      check("held_gap", 32'(dbg_ack_o), 32'h0);
      step();
      check("held_reack", 32'(dbg_ack_o), 32'h1);
      check("held_new", dbg_rdata_o, 32'h99);
      dbg_req_i = 1'b0;
      step();

      // Reset during the 10th INIT cycle with a debug request pending
      rst = 1'b0;
      step(); step();
      rst = 1'b1;
      for (int i = 0; i < 9; i++) step();
      rst = 1'b0;
      dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 5'd5;
      step();
      check("midrst_ack", 32'(dbg_ack_o), 32'h0);
      step();
      rst = 1'b1;
      wait_init("reinit");
      dbg_req_i = 1'b0;
      raddr_i = {5'd4, 5'd5};
      #1;
      check("reinit_x5", rdata_o[31:0], 32'h0);
      check("reinit_x4", rdata_o[63:32], 32'h0);
      step(); step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
